slot_allocator: RTL and testbench
=================================

# slot_allocator

- Owns the 20-entry slot-occupancy register for the labelling/tracking path.
- Grants free slot IDs on request and releases them on free commands.
- Drives the first-free priority encoder and one-hot index decoder and consumes their results, so the pair is pure combinational logic wrapped by this stateful block.
- Reports allocation status, fill level and peak fill to the downstream control logic.

## Interface
Parameters:
- NSLOT, 20: number of slots. Only 20 is supported; it matches the encoder/decoder width.
- IDW, 5: slot-ID width. IDs are 1-based (1..20); 0 means "none".

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_req  in  1  request one slot this cycle
- free_req  in  1  release slot free_id this cycle
- free_id  in  IDW  slot to release (1..20)
- clear  in  1  synchronous release of all slots
- occ  out  NSLOT  occupancy vector, bit i = slot i+1 used; drives the encoder input
- ff_idx  in  IDW  encoder result: 1-based first-zero index of occ, 0 if occ is all ones
- dec_idx  out  IDW  equals free_id combinationally; drives the decoder input
- dec_onehot  in  NSLOT  decoder result: bit (dec_idx-1) set, all zero for dec_idx 0 or >20
- alloc_ack  out  1  one-cycle pulse, slot granted
- alloc_id  out  IDW  granted ID, valid with alloc_ack, holds until the next grant
- alloc_fail  out  1  one-cycle pulse, request refused because all slots were full
- free_err  out  1  one-cycle pulse, illegal free (slot not in use or ID out of range)
- used_cnt  out  IDW  number of occupied slots, 0..20
- peak_cnt  out  IDW  maximum used_cnt since reset or clear
- full  out  1  used_cnt == 20
- empty  out  1  used_cnt == 0

## Operation
- All outputs except dec_idx are registered.
- Reset values (asynchronous): occ=0, alloc_ack=0, alloc_id=0, alloc_fail=0, free_err=0, used_cnt=0, peak_cnt=0, full=0, empty=1.
- Allocation, evaluated at each edge with alloc_req=1:
  - ff_idx!=0: set occ[ff_idx-1], alloc_ack=1, alloc_id=ff_idx.
  - ff_idx==0: occ unchanged, alloc_fail=1.
- Free, evaluated at each edge with free_req=1:
  - (occ & dec_onehot)!=0: occ &= ~dec_onehot.
  - Otherwise (slot unused, or free_id 0 or >20): free_err=1, occ unchanged.
- Simultaneous alloc and free in one cycle:
  - Both are evaluated against the pre-edge occ.
  - A slot freed this cycle is not re-granted this cycle.
  - When full, the alloc fails even if the free succeeds.
  - No conflict is possible, because the allocated bit is zero in the pre-edge occ while the freed bit is one.
- used_cnt next value = used_cnt + (alloc ok) - (free ok): net +1, -1 or 0.
- full and empty are registered from the next used_cnt value, so they are always consistent with used_cnt in the same cycle.
- peak_cnt updates to the next used_cnt whenever that value is larger than peak_cnt.
- clear=1 has highest priority:
  - Next-state occ=0, used_cnt=0, peak_cnt=0, empty=1, full=0.
  - alloc_req and free_req are ignored that cycle: no ack, fail or err pulse.
  - alloc_id holds its value.
- Requests are single-cycle commands with no back-pressure. Holding alloc_req high grants one slot per cycle.
- Invariant: used_cnt equals popcount(occ) at all times.

## Timing
- Encoder/decoder path: occ -> ff_idx and free_id -> dec_idx -> dec_onehot are combinational and must settle within one cycle.
- Latency: a request sampled at edge N produces occ, the pulse outputs and the counts after edge N.
- Pulses are exactly one cycle wide and are deasserted in every cycle without a corresponding request.
- A back-to-back alloc uses the updated occ. Consecutive grants from empty are 1, 2, 3, ...
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Operation resumes at the first edge after rst_n deasserts.

## Test plan
- Reset, then alloc_req held for 21 cycles:
  - Cycles 1–20: alloc_id 1..20 with alloc_ack each cycle.
  - full=1 after the 20th grant.
  - Cycle 21: alloc_fail=1, used_cnt=20, peak_cnt=20.
- From full, free slots 7 then 3, then two allocs:
  - Grants are 3 then 7 (lowest free first).
  - used_cnt goes 19, 18, 19, 20.
- Error cases, each producing free_err=1 with occ and used_cnt unchanged:
  - Free an unused slot 5.
  - free_id=0.
  - free_id=25.
- From full, alloc_req and free_req(12) in the same cycle:
  - alloc_fail=1, occ[11]=0, used_cnt=19.
  - The next alloc grants 12.
- With 4 slots used, assert clear together with alloc_req and free_req:
  - Next cycle: occ=0, used_cnt=0, peak_cnt=0, empty=1.
  - No ack, fail or err pulse.
- Allocate 10 slots, then pulse rst_n low between clock edges:
  - All outputs return to reset values immediately.
  - The first alloc after release grants 1.

Source files
------------

// File: rtl/slot_allocator_if.sv
// Command, status and encoder/decoder signals of the slot allocator, bundled with
// a master (requester + encoder/decoder side) and a slave (allocator) view.
interface slot_allocator_if #(
  parameter int NSLOT = 20,
  parameter int IDW   = 5
);
  logic             alloc_req;
  logic             free_req;
  logic [IDW-1:0]   free_id;
  logic             clear;
  logic [NSLOT-1:0] occ;
  logic [IDW-1:0]   ff_idx;
  logic [IDW-1:0]   dec_idx;
  logic [NSLOT-1:0] dec_onehot;
  logic             alloc_ack;
  logic [IDW-1:0]   alloc_id;
  logic             alloc_fail;
  logic             free_err;
  logic [IDW-1:0]   used_cnt;
  logic [IDW-1:0]   peak_cnt;
  logic             full;
  logic             empty;

  modport master (
    output alloc_req, free_req, free_id, clear, ff_idx, dec_onehot,
    input  occ, dec_idx, alloc_ack, alloc_id, alloc_fail, free_err,
           used_cnt, peak_cnt, full, empty
  );

  modport slave (
    input  alloc_req, free_req, free_id, clear, ff_idx, dec_onehot,
    output occ, dec_idx, alloc_ack, alloc_id, alloc_fail, free_err,
           used_cnt, peak_cnt, full, empty
  );
endinterface

// File: rtl/slot_allocator.sv
// Slot-occupancy owner: grants lowest free slot IDs (1-based) using an external
// first-free encoder and releases slots using an external one-hot decoder.
module slot_allocator #(
  parameter int NSLOT = 20,
  parameter int IDW   = 5
) (
  input logic              clk,
  input logic              rst_n,
  slot_allocator_if.slave  bus
);

  // Handshake: alloc_req/free_req/clear are single-cycle commands sampled on
  // every rising edge with no back-pressure; ack/fail/err answer one cycle later.

  logic [NSLOT-1:0] r_occ;
  logic             r_alloc_ack;
  logic [IDW-1:0]   r_alloc_id;
  logic             r_alloc_fail;
  logic             r_free_err;
  logic [IDW-1:0]   r_used_cnt;
  logic [IDW-1:0]   r_peak_cnt;
  logic             r_full;
  logic             r_empty;

  logic [NSLOT-1:0] w_alloc_mask;
  logic [NSLOT-1:0] w_free_hit;
  logic [NSLOT-1:0] w_occ_next;
  logic             w_alloc_ok;
  logic             w_free_ok;
  logic [IDW-1:0]   w_used_next;

  // An out-of-range encoder result yields an empty mask and is treated as "none".
  always_comb begin
    w_alloc_mask = '0;
    for (int i = 0; i < NSLOT; i++) begin
      w_alloc_mask[i] = (bus.ff_idx == IDW'(i + 1));
    end
  end

  always_comb begin
    w_alloc_ok  = bus.alloc_req && (|w_alloc_mask);
    w_free_hit  = r_occ & bus.dec_onehot;
    w_free_ok   = bus.free_req && (|w_free_hit);
    w_occ_next  = r_occ;
    if (w_alloc_ok) w_occ_next = w_occ_next | w_alloc_mask;
    if (w_free_ok)  w_occ_next = w_occ_next & ~w_free_hit;
    w_used_next = r_used_cnt + {{(IDW-1){1'b0}}, w_alloc_ok}
                             - {{(IDW-1){1'b0}}, w_free_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ        <= '0;
      r_alloc_ack  <= 1'b0;
      r_alloc_id   <= '0;
      r_alloc_fail <= 1'b0;
      r_free_err   <= 1'b0;
      r_used_cnt   <= '0;
      r_peak_cnt   <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
    end else if (bus.clear) begin
      r_occ        <= '0;
      r_alloc_ack  <= 1'b0;
      r_alloc_fail <= 1'b0;
      r_free_err   <= 1'b0;
      r_used_cnt   <= '0;
      r_peak_cnt   <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
    end else begin
      r_occ        <= w_occ_next;
      r_alloc_ack  <= w_alloc_ok;
      if (w_alloc_ok) r_alloc_id <= bus.ff_idx;
      r_alloc_fail <= bus.alloc_req && !w_alloc_ok;
      r_free_err   <= bus.free_req && !w_free_ok;
      r_used_cnt   <= w_used_next;
      if (w_used_next > r_peak_cnt) r_peak_cnt <= w_used_next;
      r_full       <= (w_used_next == IDW'(NSLOT));
      r_empty      <= (w_used_next == '0);
    end
  end

  assign bus.occ        = r_occ;
  assign bus.dec_idx    = bus.free_id;
  assign bus.alloc_ack  = r_alloc_ack;
  assign bus.alloc_id   = r_alloc_id;
  assign bus.alloc_fail = r_alloc_fail;
  assign bus.free_err   = r_free_err;
  assign bus.used_cnt   = r_used_cnt;
  assign bus.peak_cnt   = r_peak_cnt;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;

endmodule

// File: tb/tb_slot_allocator.sv
// Bench for slot_allocator: supplies the encoder/decoder, drives directed and
// random commands, and compares against an array-based model of the slot pool.
module tb_slot_allocator;

  localparam int NSLOT = 20;
  localparam int IDW   = 5;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  slot_allocator_if #(.NSLOT(NSLOT), .IDW(IDW)) bus ();

  slot_allocator #(.NSLOT(NSLOT), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- encoder / decoder environment ----------------
  always_comb begin
    bus.ff_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!bus.occ[i]) bus.ff_idx = IDW'(i + 1);
    end
  end

  always_comb begin
    bus.dec_onehot = '0;
    for (int i = 0; i < NSLOT; i++) begin
      bus.dec_onehot[i] = (bus.dec_idx == IDW'(i + 1));
    end
  end

  // ---------------- reference model ----------------
  bit             m_used[NSLOT];
  int             m_peak;
  logic [IDW-1:0] m_id;
  bit             m_ack, m_fail, m_err;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NSLOT; i++) n += m_used[i];
    return n;
  endfunction

  function automatic logic [NSLOT-1:0] m_occ_vec();
    logic [NSLOT-1:0] v = '0;
    for (int i = 0; i < NSLOT; i++) v[i] = m_used[i];
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NSLOT; i++) m_used[i] = 1'b0;
    m_peak = 0; m_id = '0; m_ack = 0; m_fail = 0; m_err = 0;
  endfunction

  function automatic void m_step(bit a, bit f, int id, bit c);
    bit pre[NSLOT];
    int slot;
    m_ack = 0; m_fail = 0; m_err = 0;
    if (c) begin
      for (int i = 0; i < NSLOT; i++) m_used[i] = 1'b0;
      m_peak = 0;
      return;
    end
    pre = m_used;
    if (a) begin
      slot = -1;
      for (int i = NSLOT - 1; i >= 0; i--) if (!pre[i]) slot = i;
      if (slot >= 0) begin m_used[slot] = 1'b1; m_ack = 1; m_id = IDW'(slot + 1); end
      else m_fail = 1;
    end
    if (f) begin
      if (id >= 1 && id <= NSLOT && pre[id-1]) m_used[id-1] = 1'b0;
      else m_err = 1;
    end
    if (m_count() > m_peak) m_peak = m_count();
  endfunction

  function automatic logic [39:0] m_vec();
    int u = m_count();
    return {m_occ_vec(), m_ack, m_id, m_fail, m_err, IDW'(u), IDW'(m_peak),
            (u == NSLOT), (u == 0)};
  endfunction

  function automatic logic [39:0] dut_vec();
    return {bus.occ, bus.alloc_ack, bus.alloc_id, bus.alloc_fail, bus.free_err,
            bus.used_cnt, bus.peak_cnt, bus.full, bus.empty};
  endfunction

  // ---------------- driver ----------------
  // Called 1 time unit after an edge; applies one command for the next edge.
  task automatic drive(bit a, bit f, int id, bit c);
    bus.alloc_req = a;
    bus.free_req  = f;
    bus.free_id   = IDW'(id);
    bus.clear     = c;
    m_step(a, f, id, c);
    @(posedge clk);
    #1;
    bus.alloc_req = 1'b0;
    bus.free_req  = 1'b0;
    bus.free_id   = '0;
    bus.clear     = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.alloc_req = 1'b0; bus.free_req = 1'b0; bus.free_id = '0; bus.clear = 1'b0;
    m_reset();
    #12;
    n_cmp++;
    if (dut_vec() !== 40'h00000_0_00_0_0_00_00_0_1 >> 0 && dut_vec() !== {20'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {20'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1});
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.used_cnt !== 5'd0) begin
      n_fail++; $display("FAIL idle_after_reset: empty=%b used=%0d expected empty=1 used=0", bus.empty, bus.used_cnt);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= NSLOT; i++) begin
      drive(1, 0, 0, 0);
      n_cmp++;
      if (bus.alloc_ack !== 1'b1 || bus.alloc_id !== IDW'(i) || bus.alloc_fail !== 1'b0) begin
        n_fail++; $display("FAIL fill_grant_%0d: ack=%b id=%0d fail=%b expected ack=1 id=%0d fail=0", i, bus.alloc_ack, bus.alloc_id, bus.alloc_fail, i);
      end
    end
    n_cmp++;
    if (bus.full !== 1'b1 || bus.occ !== 20'hFFFFF) begin
      n_fail++; $display("FAIL fill_full: full=%b occ=%h expected full=1 occ=fffff", bus.full, bus.occ);
    end
    drive(1, 0, 0, 0);
    n_cmp++;
    if (bus.alloc_fail !== 1'b1 || bus.alloc_ack !== 1'b0 || bus.used_cnt !== 5'd20 || bus.peak_cnt !== 5'd20) begin
      n_fail++; $display("FAIL fill_overflow: fail=%b ack=%b used=%0d peak=%0d expected 1 0 20 20", bus.alloc_fail, bus.alloc_ack, bus.used_cnt, bus.peak_cnt);
    end
  endtask

  task automatic test_free_order();
    int exp_used[4] = '{19, 18, 19, 20};
    logic [IDW-1:0] got_ids[2];
    drive(0, 1, 7, 0);
    n_cmp++;
    if (bus.used_cnt !== IDW'(exp_used[0])) begin n_fail++; $display("FAIL free7_used: got %0d expected %0d", bus.used_cnt, exp_used[0]); end
    drive(0, 1, 3, 0);
    n_cmp++;
    if (bus.used_cnt !== IDW'(exp_used[1])) begin n_fail++; $display("FAIL free3_used: got %0d expected %0d", bus.used_cnt, exp_used[1]); end
    drive(1, 0, 0, 0);
    got_ids[0] = bus.alloc_id;
    n_cmp++;
    if (bus.used_cnt !== IDW'(exp_used[2])) begin n_fail++; $display("FAIL realloc1_used: got %0d expected %0d", bus.used_cnt, exp_used[2]); end
    drive(1, 0, 0, 0);
    got_ids[1] = bus.alloc_id;
    n_cmp++;
    if (bus.used_cnt !== IDW'(exp_used[3])) begin n_fail++; $display("FAIL realloc2_used: got %0d expected %0d", bus.used_cnt, exp_used[3]); end
    n_cmp++;
    if (got_ids[0] !== 5'd3 || got_ids[1] !== 5'd7) begin
      n_fail++; $display("FAIL realloc_order: got %0d,%0d expected 3,7", got_ids[0], got_ids[1]);
    end
  endtask

  task automatic test_free_errors();
    int bad_ids[3] = '{5, 0, 25};
    logic [NSLOT-1:0] occ_before;
    drive(0, 1, 5, 0);
    n_cmp++;
    if (bus.free_err !== 1'b0 || bus.occ[4] !== 1'b0) begin
      n_fail++; $display("FAIL free5_ok: err=%b occ4=%b expected 0 0", bus.free_err, bus.occ[4]);
    end
    foreach (bad_ids[k]) begin
      occ_before = bus.occ;
      drive(0, 1, bad_ids[k], 0);
      n_cmp++;
      if (bus.free_err !== 1'b1 || bus.occ !== m_occ_vec() || bus.occ !== occ_before || bus.used_cnt !== 5'd19) begin
        n_fail++; $display("FAIL free_err_id%0d: err=%b occ=%h used=%0d expected err=1 occ=%h used=19", bad_ids[k], bus.free_err, bus.occ, bus.used_cnt, m_occ_vec());
      end
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if (bus.free_err !== 1'b0) begin n_fail++; $display("FAIL free_err_pulse: err=%b expected 0", bus.free_err); end
    drive(1, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 12, 0);
    n_cmp++;
    if (bus.alloc_fail !== 1'b1 || bus.occ[11] !== 1'b0 || bus.used_cnt !== 5'd19 || bus.free_err !== 1'b0) begin
      n_fail++; $display("FAIL simul_full: fail=%b occ11=%b used=%0d err=%b expected 1 0 19 0", bus.alloc_fail, bus.occ[11], bus.used_cnt, bus.free_err);
    end
    drive(1, 0, 0, 0);
    n_cmp++;
    if (bus.alloc_ack !== 1'b1 || bus.alloc_id !== 5'd12 || bus.full !== 1'b1) begin
      n_fail++; $display("FAIL simul_regrant: ack=%b id=%0d full=%b expected 1 12 1", bus.alloc_ack, bus.alloc_id, bus.full);
    end
  endtask

  task automatic test_clear();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0);
    drive(1, 1, 2, 1);
    n_cmp++;
    if (bus.occ !== '0 || bus.used_cnt !== 5'd0 || bus.peak_cnt !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL clear_state: occ=%h used=%0d peak=%0d empty=%b full=%b expected 0 0 0 1 0", bus.occ, bus.used_cnt, bus.peak_cnt, bus.empty, bus.full);
    end
    n_cmp++;
    if (bus.alloc_ack !== 1'b0 || bus.alloc_fail !== 1'b0 || bus.free_err !== 1'b0 || bus.alloc_id !== 5'd4) begin
      n_fail++; $display("FAIL clear_pulses: ack=%b fail=%b err=%b id=%0d expected 0 0 0 4", bus.alloc_ack, bus.alloc_fail, bus.free_err, bus.alloc_id);
    end
  endtask

  task automatic test_random();
    int a, f, c, id, slot;
    for (int cyc = 0; cyc < 600; cyc++) begin
      c = ($urandom_range(0, 99) < 2);
      a = ($urandom_range(0, 99) < 55);
      f = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 9) == 0) id = $urandom_range(0, 31);
      else begin
        slot = $urandom_range(0, NSLOT - 1);
        id = slot + 1;
        for (int k = 0; k < NSLOT; k++) if (m_used[(slot + k) % NSLOT]) begin id = ((slot + k) % NSLOT) + 1; break; end
      end
      drive(a[0], f[0], id, c[0]);
      n_cmp++;
      if (dut_vec() !== m_vec()) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", cyc, dut_vec(), m_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0);
    n_cmp++;
    if (bus.used_cnt !== 5'd10 || bus.alloc_id !== 5'd10) begin
      n_fail++; $display("FAIL pre_reset_fill: used=%0d id=%0d expected 10 10", bus.used_cnt, bus.alloc_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== {20'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", dut_vec(), {20'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1});
    end
    #1;
    rst_n = 1'b1;
    m_reset();
    drive(1, 0, 0, 0);
    n_cmp++;
    if (bus.alloc_ack !== 1'b1 || bus.alloc_id !== 5'd1 || bus.used_cnt !== 5'd1) begin
      n_fail++; $display("FAIL post_reset_grant: ack=%b id=%0d used=%0d expected 1 1 1", bus.alloc_ack, bus.alloc_id, bus.used_cnt);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_fill();
    test_free_order();
    test_free_errors();
    test_simultaneous();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
